// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and the helper that sizes the pixel position counters.
package cnn_pkg;

    localparam int CNN_Y = 8;
    localparam int CNN_W = 8;
    localparam int CNN_H = 8;

    // Counter width for a modulo-n counter; a 1-entry range still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels; a single address is read (old contents) and written in the same cycle.
module line_buffer
    import cnn_pkg::*;
#(
    parameter  int Y  = CNN_Y,
    parameter  int W  = CNN_W,
    localparam int AW = cnt_w(W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [Y-1:0]  wr_data,
    output logic [Y-1:0]  rd_data
);

    logic [Y-1:0] mem_q [W];
    logic [Y-1:0] mem_d [W];

    // Read returns the stored pixel, so the caller sees the value from one row earlier.
    assign rd_data = mem_q[addr];

    // Next contents: overwrite the addressed entry on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = wr_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage array; contents are don't-care after reset, so it is not cleared.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/column_tap3_feeder.sv
// Raster pixel stream to vertically aligned tap triples (rows r-2, r-1, r) for a 3-input adder.
module column_tap3_feeder
    import cnn_pkg::*;
#(
    parameter  int Y     = CNN_Y,
    parameter  int W     = CNN_W,
    parameter  int H     = CNN_H,
    localparam int COL_W = cnt_w(W),
    localparam int ROW_W = cnt_w(H)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic signed [Y-1:0] in_data,
    output logic                out_valid,
    output logic signed [Y-1:0] data1,
    output logic signed [Y-1:0] data2,
    output logic signed [Y-1:0] data3,
    output logic                frame_done
);

    logic [COL_W-1:0] col_q, col_d, cur_col_s;
    logic [ROW_W-1:0] row_q, row_d, cur_row_s;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [Y-1:0]     data1_q, data1_d;
    logic [Y-1:0]     data2_q, data2_d;
    logic [Y-1:0]     data3_q, data3_d;
    logic [Y-1:0]     lb1_rd_s, lb2_rd_s;
    logic             lb_we_s;

    // Start of frame forces the accepted pixel to (0,0), abandoning any frame in flight.
    assign cur_col_s = in_sof ? {COL_W{1'b0}} : col_q;
    assign cur_row_s = in_sof ? {ROW_W{1'b0}} : row_q;
    assign lb_we_s   = in_valid & ~rst;

    line_buffer #(.Y(Y), .W(W)) u_lb1 (
        .clk     (clk),
        .we      (lb_we_s),
        .addr    (cur_col_s),
        .wr_data (in_data),
        .rd_data (lb1_rd_s)
    );

    // lb2 is fed from lb1's old contents, so it trails lb1 by exactly one row.
    line_buffer #(.Y(Y), .W(W)) u_lb2 (
        .clk     (clk),
        .we      (lb_we_s),
        .addr    (cur_col_s),
        .wr_data (lb1_rd_s),
        .rd_data (lb2_rd_s)
    );

    // Position advance and output stage next-state.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        data1_d      = data1_q;
        data2_d      = data2_q;
        data3_d      = data3_q;
        if (in_valid) begin
            data1_d      = lb2_rd_s;
            data2_d      = lb1_rd_s;
            data3_d      = in_data;
            out_valid_d  = (cur_row_s >= ROW_W'(2));
            frame_done_d = (cur_row_s == ROW_W'(H - 1)) && (cur_col_s == COL_W'(W - 1));
            if (cur_col_s == COL_W'(W - 1)) begin
                col_d = {COL_W{1'b0}};
                if (cur_row_s == ROW_W'(H - 1)) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = cur_row_s + ROW_W'(1);
                end
            end else begin
                col_d = cur_col_s + COL_W'(1);
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // State and output registers; reset wins over any input activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= {COL_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data1_q      <= {Y{1'b0}};
            data2_q      <= {Y{1'b0}};
            data3_q      <= {Y{1'b0}};
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            data3_q      <= data3_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign data1      = data1_q;
    assign data2      = data2_q;
    assign data3      = data3_q;

endmodule

// File: tb/tb_column_tap3_feeder.sv
// Self-checking bench for column_tap3_feeder (W=4, H=4, Y=8) against a frame-image reference model.
module tb_column_tap3_feeder;

    localparam int W = 4;
    localparam int H = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic signed [7:0] in_data = 8'sd0;
    logic              out_valid, frame_done;
    logic signed [7:0] data1, data2, data3;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame as a 2-D image plus the raster position.
    logic signed [7:0] img [H][W];
    int                m_row = 0, m_col = 0;
    int                last_r = 0, last_c = 0;
    logic              exp_valid = 1'b0, exp_fd = 1'b0;
    logic signed [7:0] exp_d1 = 8'sd0, exp_d2 = 8'sd0, exp_d3 = 8'sd0;
    logic              k12 = 1'b1, k3 = 1'b1;

    column_tap3_feeder #(.Y(8), .W(W), .H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Apply one cycle of input, advance the model, and land 1 time unit after the edge.
    task automatic drive(input logic v, input logic sof, input logic [7:0] d);
        int r, c;
        rst = 1'b0; in_valid = v; in_sof = sof; in_data = d;
        if (v) begin
            r = sof ? 0 : m_row;
            c = sof ? 0 : m_col;
            img[r][c] = d;
            exp_valid = (r >= 2);
            exp_fd    = (r == H - 1) && (c == W - 1);
            exp_d3    = d;
            k3        = 1'b1;
            if (r >= 2) begin
                exp_d1 = img[r-2][c];
                exp_d2 = img[r-1][c];
                k12    = 1'b1;
            end else begin
                k12    = 1'b0;
            end
            last_r = r; last_c = c;
            m_col  = (c + 1) % W;
            m_row  = (c == W - 1) ? (r + 1) % H : r;
        end else begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0;
        exp_valid = 1'b0; exp_fd = 1'b0;
        exp_d1 = 8'sd0; exp_d2 = 8'sd0; exp_d3 = 8'sd0;
        k12 = 1'b1; k3 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_data = 8'($urandom);
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || data1 !== 8'sd0 || data2 !== 8'sd0 || data3 !== 8'sd0) begin
            errors++;
            $display("FAIL reset: got v=%b fd=%b d=%h,%h,%h want all zero", out_valid, frame_done, data1, data2, data3);
        end
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic test_frame();
        int nv = 0;
        for (int i = 0; i < W * H; i++) begin
            drive(1'b1, i == 0, 8'((i / W) * 16 + (i % W)));
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL frame i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
            if (out_valid === 1'b1) nv++;
            if (i == 9) begin
                checks++;
                if (out_valid !== 1'b1 || data1 !== 8'sd1 || data2 !== 8'sd17 || data3 !== 8'sd33) begin
                    errors++;
                    $display("FAIL frame_tap21: got v=%b %0d,%0d,%0d want 1 1,17,33", out_valid, data1, data2, data3);
                end
            end
            if (i == 15) begin
                checks++;
                if (frame_done !== 1'b1 || data1 !== 8'sd19 || data2 !== 8'sd35 || data3 !== 8'sd51) begin
                    errors++;
                    $display("FAIL frame_tap33: got fd=%b %0d,%0d,%0d want 1 19,35,51", frame_done, data1, data2, data3);
                end
            end
        end
        checks++;
        if (nv != 8) begin
            errors++;
            $display("FAIL frame_count: got %0d triples want 8", nv);
        end
    endtask

    task automatic test_gaps();
        int nv = 0;
        for (int i = 0; i < 2 * W * H; i++) begin
            if (i % 2 == 1) drive(1'b0, 1'b0, 8'($urandom));
            else            drive(1'b1, i == 0, 8'(((i / 2) / W) * 16 + ((i / 2) % W)));
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL gaps i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
            if (out_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 8) begin
            errors++;
            $display("FAIL gaps_count: got %0d triples want 8", nv);
        end
    endtask

    task automatic test_signed();
        logic [7:0] col2 [4];
        col2[0] = 8'h80; col2[1] = 8'h7F; col2[2] = 8'hFF; col2[3] = 8'h00;
        for (int i = 0; i < W * H; i++) begin
            drive(1'b1, i == 0, (i % W == 2) ? col2[i / W] : 8'($urandom));
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL signed i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
            if (i == 10) begin
                checks++;
                if ({data1, data2, data3} !== 24'h807FFF) begin
                    errors++;
                    $display("FAIL signed_tap22: got %h,%h,%h want 80,7f,ff", data1, data2, data3);
                end
            end
            if (i == 14) begin
                checks++;
                if ({data1, data2, data3} !== 24'h7FFF00) begin
                    errors++;
                    $display("FAIL signed_tap32: got %h,%h,%h want 7f,ff,00", data1, data2, data3);
                end
            end
        end
    endtask

    task automatic test_abort();
        int nfd = 0;
        int first_v = -1;
        for (int i = 0; i < 9 + W * H; i++) begin
            drive(1'b1, (i == 0) || (i == 9), 8'($urandom));
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL abort i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
            if (frame_done === 1'b1) nfd++;
            if (i >= 9 && out_valid === 1'b1 && first_v < 0) first_v = i - 9;
        end
        checks++;
        if (first_v != 8 || nfd != 1) begin
            errors++;
            $display("FAIL abort_restart: got first triple at accept %0d, %0d frame_done want 8, 1", first_v, nfd);
        end
    endtask

    task automatic test_reset_midframe();
        int nv = 0;
        int nfd = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 8'($urandom));
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || data1 !== 8'sd0 || data2 !== 8'sd0 || data3 !== 8'sd0) begin
            errors++;
            $display("FAIL midreset: got v=%b fd=%b d=%h,%h,%h want all zero", out_valid, frame_done, data1, data2, data3);
        end
        for (int i = 0; i < W * H; i++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL midreset i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
            if (out_valid === 1'b1) nv++;
            if (frame_done === 1'b1) nfd++;
        end
        checks++;
        if (nv != 8 || nfd != 1 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_frame: got %0d triples %0d done last=%b want 8 1 1", nv, nfd, frame_done);
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        int nfd = 0;
        logic [7:0] f2 [3];
        for (int i = 0; i < 2 * W * H; i++) begin
            logic [7:0] px;
            px = 8'($urandom);
            if (i == 16) f2[0] = px;
            if (i == 20) f2[1] = px;
            if (i == 24) f2[2] = px;
            drive(1'b1, i == 0, px);
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL b2b i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
            if (out_valid === 1'b1) nv++;
            if (frame_done === 1'b1) nfd++;
            if (i == 24) begin
                checks++;
                if ({data1, data2, data3} !== {f2[0], f2[1], f2[2]}) begin
                    errors++;
                    $display("FAIL b2b_tap20: got %h,%h,%h want %h,%h,%h", data1, data2, data3, f2[0], f2[1], f2[2]);
                end
            end
        end
        checks++;
        if (nv != 16 || nfd != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d triples %0d done want 16 2", nv, nfd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 20) == 0, 8'($urandom));
            checks++;
            if (out_valid !== exp_valid || frame_done !== exp_fd || (k3 && data3 !== exp_d3) || (k12 && (data1 !== exp_d1 || data2 !== exp_d2))) begin
                errors++;
                $display("FAIL random i=%0d: got v=%b fd=%b %h,%h,%h want v=%b fd=%b %h,%h,%h", i, out_valid, frame_done, data1, data2, data3, exp_valid, exp_fd, exp_d1, exp_d2, exp_d3);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_frame();
        test_gaps();
        test_signed();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
